inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp.sv | 109 ++++++++++
 tb/tb_inst_mem_resp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// Instruction memory with a fixed-latency fetch response, fault flagging for bad
// addresses, and a side-band program-loader write port.
module inst_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the populated word range.
  function automatic logic addr_fault(input logic [31:0] a);
    addr_fault = (a[1:0] != 2'd0) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           pend_data;
  logic                  pend_err;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic                  fetch_bad;
  logic                  accept;
  logic [31:0]           fetch_word;

  assign fetch_idx  = addr_i[DEPTH_LOG2+1:2];
  assign ld_idx     = ld_addr_i[DEPTH_LOG2+1:2];
  assign fetch_bad  = addr_fault(addr_i);
  assign accept     = ce_i && (state != WAIT);
  // Storage is sampled before this edge's loader write lands: read-before-write.
  assign fetch_word = fetch_bad ? 32'h0000_0000 : mem[fetch_idx];
  assign busy_o     = (state == WAIT) || ((WAIT_CYCLES > 0) && rst && accept);

  // Loader port; reset neither clears storage nor lets writes through.
  always_ff @(posedge clk) begin
    if (rst && ld_we_i && !addr_fault(ld_addr_i)) begin
      mem[ld_idx] <= ld_data_i;
    end
  end

  // Fetch FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data_o    <= 32'h0000_0000;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      pend_data <= 32'h0000_0000;
      pend_err  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              valid_o <= 1'b1;
              data_o  <= fetch_word;
              err_o   <= fetch_bad;
            end else begin
              state     <= WAIT;
              cnt       <= CNT_LOAD;
              pend_data <= fetch_word;
              pend_err  <= fetch_bad;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            valid_o <= 1'b1;
            data_o  <= pend_data;
            err_o   <= pend_err;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: a zero-wait and a three-wait instance share
// clock, reset and loader, each with its own fetch port.
module tb_inst_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;
  logic        ce0, ce3;
  logic [31:0] addr0, addr3;
  logic [31:0] data0, data3;
  logic        valid0, valid3, busy0, busy3, err0, err3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .addr_i(addr0),
    .data_o(data0), .valid_o(valid0), .busy_o(busy0), .err_o(err0),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  inst_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ce_i(ce3), .addr_i(addr3),
    .data_o(data3), .valid_o(valid3), .busy_o(busy3), .err_o(err3),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    ce0 = 1'b0; ce3 = 1'b0; addr0 = 32'h0; addr3 = 32'h0;
    tick(); tick();
    check_eq("rst_data0",  data0,  32'h0);
    check_eq("rst_valid0", {31'd0, valid0}, 32'h0);
    check_eq("rst_busy0",  {31'd0, busy0},  32'h0);
    check_eq("rst_err0",   {31'd0, err0},   32'h0);
    check_eq("rst_data3",  data3,  32'h0);
    check_eq("rst_valid3", {31'd0, valid3}, 32'h0);

    rst = 1'b1;
    load(32'h0, 32'h3401_1100);
    load(32'h4, 32'h1111_2222);
    load(32'h8, 32'hAAAA_0000);
    load(32'hC, 32'h3333_4444);

    // Single fetch, one-cycle latency, then data held after valid drops.
    ce0 = 1'b1; addr0 = 32'h0;
    tick();
    check_eq("one_valid", {31'd0, valid0}, 32'h1);
    check_eq("one_data",  data0, 32'h3401_1100);
    check_eq("one_err",   {31'd0, err0}, 32'h0);
    ce0 = 1'b0;
    tick();
    check_eq("one_drop",  {31'd0, valid0}, 32'h0);
    check_eq("one_hold",  data0, 32'h3401_1100);

    // Back-to-back stream at one fetch per cycle.
    ce0 = 1'b1; addr0 = 32'h0;
    tick();
    check_eq("b2b0_valid", {31'd0, valid0}, 32'h1);
    check_eq("b2b0_data",  data0, 32'h3401_1100);
    check_eq("b2b0_busy",  {31'd0, busy0}, 32'h0);
    addr0 = 32'h4;
    tick();
    check_eq("b2b1_valid", {31'd0, valid0}, 32'h1);
    check_eq("b2b1_data",  data0, 32'h1111_2222);
    check_eq("b2b1_busy",  {31'd0, busy0}, 32'h0);
    addr0 = 32'h8;
    tick();
    check_eq("b2b2_valid", {31'd0, valid0}, 32'h1);
    check_eq("b2b2_data",  data0, 32'hAAAA_0000);
    check_eq("b2b2_busy",  {31'd0, busy0}, 32'h0);

    // Faulting fetches: misaligned, then out of range.
    addr0 = 32'h2;
    tick();
    check_eq("mis_valid", {31'd0, valid0}, 32'h1);
    check_eq("mis_data",  data0, 32'h0);
    check_eq("mis_err",   {31'd0, err0}, 32'h1);
    addr0 = 32'h1000;
    tick();
    check_eq("oor_data", data0, 32'h0);
    check_eq("oor_err",  {31'd0, err0}, 32'h1);
    ce0 = 1'b0;
    tick();

    // Bad loader writes aliasing word 1 must not land.
    load(32'h6, 32'hDEAD_BEEF);
    load(32'h1004, 32'hBEEF_DEAD);
    ce0 = 1'b1; addr0 = 32'h4;
    tick();
    check_eq("badld_data", data0, 32'h1111_2222);
    check_eq("badld_err",  {31'd0, err0}, 32'h0);
    ce0 = 1'b0;
    tick();

    // Same-cycle load and fetch of one word: old word, then new on refetch.
    ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'h5555_0000;
    ce0 = 1'b1; addr0 = 32'h8;
    tick();
    ld_we = 1'b0;
    check_eq("rbw_old", data0, 32'hAAAA_0000);
    tick();
    check_eq("rbw_new", data0, 32'h5555_0000);
    ce0 = 1'b0;
    tick();

    // Three wait states; a request during WAIT is dropped.
    ce3 = 1'b1; addr3 = 32'h4;
    tick();
    check_eq("w3_t1_busy",  {31'd0, busy3},  32'h1);
    check_eq("w3_t1_valid", {31'd0, valid3}, 32'h0);
    addr3 = 32'hC;
    tick();
    ce3 = 1'b0;
    check_eq("w3_t2_busy",  {31'd0, busy3},  32'h1);
    check_eq("w3_t2_valid", {31'd0, valid3}, 32'h0);
    tick();
    check_eq("w3_t3_busy",  {31'd0, busy3},  32'h1);
    check_eq("w3_t3_valid", {31'd0, valid3}, 32'h0);
    tick();
    check_eq("w3_t4_valid", {31'd0, valid3}, 32'h1);
    check_eq("w3_t4_data",  data3, 32'h1111_2222);
    check_eq("w3_t4_busy",  {31'd0, busy3},  32'h0);
    tick();
    check_eq("w3_t5_valid", {31'd0, valid3}, 32'h0);
    check_eq("w3_t5_busy",  {31'd0, busy3},  32'h0);
    check_eq("w3_t5_hold",  data3, 32'h1111_2222);

    // Reset mid-WAIT discards the fetch and blocks loader writes.
    ce3 = 1'b1; addr3 = 32'h0;
    tick();
    ce3 = 1'b0;
    tick();
    rst = 1'b0; ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'hFFFF_FFFF;
    tick();
    check_eq("mid_rst_valid", {31'd0, valid3}, 32'h0);
    check_eq("mid_rst_busy",  {31'd0, busy3},  32'h0);
    check_eq("mid_rst_data",  data3, 32'h0);
    check_eq("mid_rst_err",   {31'd0, err3},   32'h0);
    tick();
    check_eq("mid_rst_valid2", {31'd0, valid3}, 32'h0);
    rst = 1'b1; ld_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_quiet", {31'd0, valid3}, 32'h0);
    end
    ce3 = 1'b1; addr3 = 32'h0;
    tick();
    ce3 = 1'b0;
    tick(); tick();
    check_eq("post_rst_t3", {31'd0, valid3}, 32'h0);
    tick();
    check_eq("post_rst_valid", {31'd0, valid3}, 32'h1);
    check_eq("post_rst_data",  data3, 32'h3401_1100);
    check_eq("post_rst_err",   {31'd0, err3}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
